// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALU definitions: operator codes, widths and the operator decode helpers
// used by both the shared ALU and the arbiter around it.
package alu_pkg;

   localparam int NREQ = 2;
   localparam int XLEN = 32;
   localparam int OPW  = 6;

   localparam logic [OPW-1:0] ALU_ADD = 6'b011000;
   localparam logic [OPW-1:0] ALU_SUB = 6'b011001;
   localparam logic [OPW-1:0] ALU_XOR = 6'b101111;
   localparam logic [OPW-1:0] ALU_OR  = 6'b101110;
   localparam logic [OPW-1:0] ALU_AND = 6'b010101;
   localparam logic [OPW-1:0] ALU_SRA = 6'b100100;
   localparam logic [OPW-1:0] ALU_SRL = 6'b100101;
   localparam logic [OPW-1:0] ALU_SLL = 6'b100111;
   localparam logic [OPW-1:0] ALU_LTS = 6'b000000;
   localparam logic [OPW-1:0] ALU_LTU = 6'b000001;
   localparam logic [OPW-1:0] ALU_GES = 6'b001010;
   localparam logic [OPW-1:0] ALU_GEU = 6'b001011;
   localparam logic [OPW-1:0] ALU_EQ  = 6'b001100;
   localparam logic [OPW-1:0] ALU_NE  = 6'b001101;

   function automatic logic is_cmp(input logic [OPW-1:0] op);
      return op inside {ALU_LTS, ALU_LTU, ALU_GES, ALU_GEU, ALU_EQ, ALU_NE};
   endfunction

   function automatic logic is_legal(input logic [OPW-1:0] op);
      return is_cmp(op) ||
             (op inside {ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND,
                         ALU_SRA, ALU_SRL, ALU_SLL});
   endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bus of the shared ALU: packed per-requester request lanes
// plus a single tagged response channel.
interface alu_share_arbiter_if #(
   parameter int NREQ = alu_pkg::NREQ,
   parameter int XLEN = alu_pkg::XLEN,
   parameter int OPW  = alu_pkg::OPW
);
   logic [NREQ-1:0]      req_valid_i;
   logic [NREQ-1:0]      req_ready_o;
   logic [NREQ*OPW-1:0]  req_op_i;
   logic [NREQ*XLEN-1:0] req_a_i;
   logic [NREQ*XLEN-1:0] req_b_i;
   logic                 resp_valid_o;
   logic                 resp_ready_i;
   logic                 resp_id_o;
   logic [XLEN-1:0]      resp_result_o;
   logic                 resp_cmp_o;
   logic                 resp_illegal_o;

   modport master (
      output req_valid_i, req_op_i, req_a_i, req_b_i, resp_ready_i,
      input  req_ready_o, resp_valid_o, resp_id_o, resp_result_o,
             resp_cmp_o, resp_illegal_o
   );

   modport slave (
      input  req_valid_i, req_op_i, req_a_i, req_b_i, resp_ready_i,
      output req_ready_o, resp_valid_o, resp_id_o, resp_result_o,
             resp_cmp_o, resp_illegal_o
   );
endinterface

// File: rtl/alu_share_arbiter_alu.sv
// Combinational RISC-V integer ALU; compare ops return the flag both as cmp_o
// and zero-extended in result_o, unknown operators flag illegal_o.
module riscV_alu #(
   parameter int XLEN = alu_pkg::XLEN,
   parameter int OPW  = alu_pkg::OPW
) (
   input  logic [OPW-1:0]  op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic [XLEN-1:0] result_o,
   output logic            cmp_o,
   output logic            illegal_o
);
   import alu_pkg::*;

   logic [4:0] shamt;
   assign shamt = b_i[4:0];

   always_comb begin
      result_o  = '0;
      cmp_o     = 1'b0;
      illegal_o = !is_legal(op_i);
      case (op_i)
         ALU_ADD: result_o = a_i + b_i;
         ALU_SUB: result_o = a_i - b_i;
         ALU_XOR: result_o = a_i ^ b_i;
         ALU_OR:  result_o = a_i | b_i;
         ALU_AND: result_o = a_i & b_i;
         ALU_SRA: result_o = $signed(a_i) >>> shamt;
         ALU_SRL: result_o = a_i >> shamt;
         ALU_SLL: result_o = a_i << shamt;
         ALU_LTS: cmp_o = $signed(a_i) <  $signed(b_i);
         ALU_LTU: cmp_o = a_i <  b_i;
         ALU_GES: cmp_o = $signed(a_i) >= $signed(b_i);
         ALU_GEU: cmp_o = a_i >= b_i;
         ALU_EQ:  cmp_o = a_i == b_i;
         ALU_NE:  cmp_o = a_i != b_i;
         default: ;
      endcase
      if (is_cmp(op_i)) begin
         result_o = {{(XLEN-1){1'b0}}, cmp_o};
      end
   end
endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between execute (req 0) and branch/address
// (req 1) through a two-stage buffer: S1 = operands, S2 = tagged result.
module alu_share_arbiter #(
   parameter int NREQ = alu_pkg::NREQ,
   parameter int XLEN = alu_pkg::XLEN,
   parameter int OPW  = alu_pkg::OPW
) (
   input logic clk_i,
   input logic rst_i,
   alu_share_arbiter_if.slave bus
);
   import alu_pkg::*;

   logic [OPW-1:0]  req_op [NREQ];
   logic [XLEN-1:0] req_a  [NREQ];
   logic [XLEN-1:0] req_b  [NREQ];

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign req_op[gi] = bus.req_op_i[gi*OPW +: OPW];
         assign req_a[gi]  = bus.req_a_i[gi*XLEN +: XLEN];
         assign req_b[gi]  = bus.req_b_i[gi*XLEN +: XLEN];
      end
   endgenerate

   logic            s1_valid_reg;
   logic [OPW-1:0]  s1_op_reg;
   logic [XLEN-1:0] s1_a_reg;
   logic [XLEN-1:0] s1_b_reg;
   logic            s1_id_reg;

   logic            s2_valid_reg;
   logic [XLEN-1:0] s2_result_reg;
   logic            s2_cmp_reg;
   logic            s2_illegal_reg;
   logic            s2_id_reg;

   // Last granted requester; with NREQ fixed at 2 one bit is enough.
   logic            rr_ptr_reg;

   logic            s2_free;
   logic            s1_adv;
   logic            s1_free;
   logic [NREQ-1:0] grant;
   logic            accept;
   logic            acc_id;

   logic [XLEN-1:0] alu_result;
   logic            alu_cmp;
   logic            alu_illegal;

   assign s2_free = !s2_valid_reg || bus.resp_ready_i;
   assign s1_adv  = s1_valid_reg && s2_free;
   assign s1_free = !s1_valid_reg || s1_adv;

   // Under contention the requester that did not win last time goes first.
   always_comb begin
      grant = '0;
      if (!rst_i && s1_free) begin
         if (bus.req_valid_i[0] && bus.req_valid_i[1]) begin
            grant[~rr_ptr_reg] = 1'b1;
         end else begin
            grant = bus.req_valid_i;
         end
      end
   end

   assign accept = |grant;
   assign acc_id = grant[1];
   assign bus.req_ready_o = grant;

   riscV_alu #(
      .XLEN (XLEN),
      .OPW  (OPW)
   ) u_alu (
      .op_i      (s1_op_reg),
      .a_i       (s1_a_reg),
      .b_i       (s1_b_reg),
      .result_o  (alu_result),
      .cmp_o     (alu_cmp),
      .illegal_o (alu_illegal)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_valid_reg   <= 1'b0;
         s1_op_reg      <= '0;
         s1_a_reg       <= '0;
         s1_b_reg       <= '0;
         s1_id_reg      <= 1'b0;
         s2_valid_reg   <= 1'b0;
         s2_result_reg  <= '0;
         s2_cmp_reg     <= 1'b0;
         s2_illegal_reg <= 1'b0;
         s2_id_reg      <= 1'b0;
         rr_ptr_reg     <= 1'b0;
      end else begin
         if (s1_adv) begin
            s2_valid_reg   <= 1'b1;
            s2_result_reg  <= alu_result;
            s2_cmp_reg     <= alu_cmp;
            s2_illegal_reg <= alu_illegal;
            s2_id_reg      <= s1_id_reg;
         end else if (s2_free) begin
            s2_valid_reg <= 1'b0;
         end

         if (accept) begin
            s1_valid_reg <= 1'b1;
            s1_op_reg    <= req_op[acc_id];
            s1_a_reg     <= req_a[acc_id];
            s1_b_reg     <= req_b[acc_id];
            s1_id_reg    <= acc_id;
            rr_ptr_reg   <= acc_id;
         end else if (s1_adv) begin
            s1_valid_reg <= 1'b0;
         end
      end
   end

   assign bus.resp_valid_o   = s2_valid_reg;
   assign bus.resp_id_o      = s2_id_reg;
   assign bus.resp_result_o  = s2_result_reg;
   assign bus.resp_cmp_o     = s2_cmp_reg;
   assign bus.resp_illegal_o = s2_illegal_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomised bench for alu_share_arbiter: an occupancy/queue model of the
// two-slot pipeline plus a plain-arithmetic ALU reference predicts every cycle.
module tb_alu_share_arbiter;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_share_arbiter_if #(.NREQ(2), .XLEN(XLEN), .OPW(OPW)) bus ();

   alu_share_arbiter #(.NREQ(2), .XLEN(XLEN), .OPW(OPW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   typedef struct {
      logic            id;
      logic [XLEN-1:0] result;
      logic            cmp;
      logic            illegal;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   errors   = 0;
   int   n_flight = 0;
   int   n_resp   = 0;
   logic rr       = 1'b0;
   bit   acc_last = 1'b0;
   bit   known    = 1'b0;
   bit   post_rst = 1'b0;

   // Requester state: mode 0 = one shot, 1 = repeat same op, 2 = random, 3 = ADD stream
   logic            rv  [2];
   logic [OPW-1:0]  rop [2];
   logic [XLEN-1:0] ra  [2];
   logic [XLEN-1:0] rb  [2];
   int              mode[2];
   logic            rready;
   bit              rready_rand;
   logic [OPW-1:0]  legal_ops[14];

   task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   function automatic exp_t ref_alu(input logic id, input logic [OPW-1:0] op,
                                    input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      exp_t        e;
      int          sh;
      logic [63:0] ext;
      bit          c;
      bit          is_c;
      sh = int'(b[4:0]);
      e.id = id; e.result = '0; e.cmp = 1'b0; e.illegal = 1'b0;
      c = 1'b0; is_c = 1'b0;
      case (op)
         ALU_ADD: e.result = a + b;
         ALU_SUB: e.result = a + ~b + 32'd1;
         ALU_XOR: e.result = a ^ b;
         ALU_OR:  e.result = a | b;
         ALU_AND: e.result = a & b;
         ALU_SLL: e.result = a << sh;
         ALU_SRL: e.result = a >> sh;
         ALU_SRA: begin ext = {{32{a[31]}}, a} >> sh; e.result = ext[31:0]; end
         ALU_LTU: begin is_c = 1'b1; c = (a < b); end
         ALU_GEU: begin is_c = 1'b1; c = !(a < b); end
         ALU_LTS: begin is_c = 1'b1; c = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)); end
         ALU_GES: begin is_c = 1'b1; c = !((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)); end
         ALU_EQ:  begin is_c = 1'b1; c = (a == b); end
         ALU_NE:  begin is_c = 1'b1; c = (a != b); end
         default: e.illegal = 1'b1;
      endcase
      if (is_c) begin
         e.cmp    = c;
         e.result = c ? 32'd1 : 32'd0;
      end
      return e;
   endfunction

   function automatic logic [XLEN-1:0] rand_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'h0000_0001;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         5:       return 32'($urandom_range(0, 40));
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic new_req(input int k);
      rv[k]  = 1'b1;
      rop[k] = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 13)];
      ra[k]  = rand_operand();
      rb[k]  = rand_operand();
   endtask

   task automatic set_req(input int k, input logic [OPW-1:0] op,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input int m);
      rv[k] = 1'b1; rop[k] = op; ra[k] = a; rb[k] = b; mode[k] = m;
   endtask

   task automatic after_accept(input int k);
      case (mode[k])
         0: rv[k] = 1'b0;
         2: if ($urandom_range(0, 3) != 0) new_req(k); else rv[k] = 1'b0;
         3: ra[k] = ra[k] + 32'd1;
         default: ;
      endcase
   endtask

   task automatic step(input bit do_rst);
      logic [1:0] exp_ready;
      bit         exp_valid;
      exp_t       e;
      int         k;
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
         if (mode[j] == 2 && !rv[j] && $urandom_range(0, 2) != 0) new_req(j);
      end
      if (rready_rand) rready = ($urandom_range(0, 3) != 0);
      rst              = do_rst;
      bus.req_valid_i  = {rv[1], rv[0]};
      bus.req_op_i     = {rop[1], rop[0]};
      bus.req_a_i      = {ra[1], ra[0]};
      bus.req_b_i      = {rb[1], rb[0]};
      bus.resp_ready_i = rready;
      #1;
      // Two slots in flight: a new request fits unless both are held by a stalled consumer.
      exp_ready = 2'b00;
      if (!do_rst && (n_flight < 2 || rready)) begin
         if (rv[0] && rv[1]) exp_ready = rr ? 2'b01 : 2'b10;
         else                exp_ready = {rv[1], rv[0]};
      end
      exp_valid = (n_flight == 2) || (n_flight == 1 && !acc_last);
      if (known) begin
         chk("req_ready", 32'(bus.req_ready_o), 32'(exp_ready));
         chk("resp_valid", 32'(bus.resp_valid_o), 32'(exp_valid));
         if (exp_valid && exp_q.size() > 0) begin
            e = exp_q[0];
            chk("resp_id", 32'(bus.resp_id_o), 32'(e.id));
            chk("resp_result", bus.resp_result_o, e.result);
            chk("resp_cmp", 32'(bus.resp_cmp_o), 32'(e.cmp));
            chk("resp_illegal", 32'(bus.resp_illegal_o), 32'(e.illegal));
         end
         if (post_rst) begin
            chk("rst_id", 32'(bus.resp_id_o), 32'd0);
            chk("rst_result", bus.resp_result_o, 32'd0);
            chk("rst_cmp", 32'(bus.resp_cmp_o), 32'd0);
            chk("rst_illegal", 32'(bus.resp_illegal_o), 32'd0);
            post_rst = 1'b0;
         end
      end
      if (do_rst) begin
         exp_q.delete();
         n_flight = 0; rr = 1'b0; acc_last = 1'b0;
         known = 1'b1; post_rst = 1'b1;
      end else begin
         if (exp_valid && rready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_resp++;
            $display("resp %0d id=%0d result=%08h cmp=%0d illegal=%0d",
                     n_resp, e.id, e.result, e.cmp, e.illegal);
            n_flight--;
         end
         acc_last = 1'b0;
         if (exp_ready != 2'b00) begin
            k = exp_ready[1] ? 1 : 0;
            exp_q.push_back(ref_alu(exp_ready[1], rop[k], ra[k], rb[k]));
            n_flight++;
            rr       = exp_ready[1];
            acc_last = 1'b1;
            after_accept(k);
         end
      end
   endtask

   task automatic drain();
      int i;
      mode[0] = 0; mode[1] = 0;
      rready = 1'b1; rready_rand = 1'b0;
      i = 0;
      while (i < 50 && (rv[0] || rv[1] || n_flight != 0)) begin
         step(1'b0);
         i++;
      end
      chk("drain_pending", 32'(n_flight + int'(rv[0]) + int'(rv[1])), 32'd0);
   endtask

   initial begin : main
      logic [OPW-1:0]  e_op[5];
      logic [XLEN-1:0] e_a[5];
      logic [XLEN-1:0] e_b[5];
      legal_ops = '{ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_SRA, ALU_SRL,
                    ALU_SLL, ALU_LTS, ALU_LTU, ALU_GES, ALU_GEU, ALU_EQ, ALU_NE};
      for (int j = 0; j < 2; j++) begin
         rv[j] = 1'b0; rop[j] = '0; ra[j] = '0; rb[j] = '0; mode[j] = 0;
      end
      rready = 1'b1; rready_rand = 1'b0;
      bus.req_valid_i = '0; bus.req_op_i = '0; bus.req_a_i = '0; bus.req_b_i = '0;
      bus.resp_ready_i = 1'b1;

      step(1'b1);
      step(1'b1);

      // Single request
      set_req(0, ALU_ADD, 32'd1, 32'd2, 0);
      drain();

      // Contention: both held valid, grants alternate
      set_req(0, ALU_SUB, 32'd1, 32'd2, 1);
      set_req(1, ALU_LTS, 32'd1, 32'd2, 1);
      repeat (8) step(1'b0);
      drain();

      // Backpressure with a streaming requester
      rready = 1'b0;
      set_req(0, ALU_ADD, 32'd100, 32'd7, 3);
      repeat (5) step(1'b0);
      drain();

      // Shift and compare edges
      e_op = '{ALU_SRA, ALU_SRL, ALU_SLL, ALU_GEU, ALU_NE};
      e_a  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0};
      e_b  = '{32'd1, 32'd1, 32'd33, 32'd1, 32'd0};
      for (int j = 0; j < 5; j++) begin
         set_req(j % 2, e_op[j], e_a[j], e_b[j], 0);
         drain();
      end

      // Undefined operator from req 1
      set_req(1, 6'b111111, 32'd5, 32'd7, 0);
      drain();

      // Reset with both stages full and the consumer stalled
      rready = 1'b0;
      set_req(0, ALU_ADD, 32'd10, 32'd20, 3);
      repeat (4) step(1'b0);
      step(1'b1);
      set_req(0, ALU_ADD, 32'd5, 32'd6, 0);
      set_req(1, ALU_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0);
      drain();

      // Randomised traffic with random backpressure
      mode[0] = 2; mode[1] = 2;
      rready_rand = 1'b1;
      repeat (3000) step(1'b0);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
